// File: rtl/timer_pkg.sv
// Shared types and constants for the two-stage countdown timer controller.
package timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EDIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
    localparam logic [7:0] SEC_WRAP      = 8'h59;

    function automatic int unsigned bcd_width(input int unsigned digits);
        return 4 * digits;
    endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// Loadable packed-BCD down counter; optional min:sec borrow on the two low digits.
module bcd_down_counter
    import timer_pkg::*;
#(
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned MIN_SEC = 1
) (
    input  logic                         clk,
    input  logic                         reseta,
    input  logic                         load,
    input  logic [bcd_width(DIGITS)-1:0] load_val,
    input  logic                         dec,
    output logic [bcd_width(DIGITS)-1:0] value,
    output logic                         is_zero,
    output logic                         is_one
);

    localparam int unsigned W = bcd_width(DIGITS);

    logic [W-1:0] dec_val;
    logic         borrow;

    // Ripple borrow across digits; an all-zero seconds pair then becomes 59 instead of 99.
    always_comb begin
        dec_val = value;
        borrow  = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (borrow) begin
                if (value[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = value[4*i +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
        if (MIN_SEC != 0 && value[7:0] == 8'h00) begin
            dec_val[7:0] = SEC_WRAP;
        end
    end

    always_ff @(posedge clk or negedge reseta) begin
        if (!reseta) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (dec) begin
            value <= dec_val;
        end
    end

    assign is_zero = (value == W'(0));
    assign is_one  = (value == W'(1));

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Keypad-programmed two-stage countdown timer: preset entry, run/pause, chained stages, alarm.
module countdown_timer_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned MIN_SEC  = 1
) (
    input  logic                         clk,
    input  logic                         reseta,
    input  logic                         key_valid,
    input  logic [3:0]                   key_code,
    input  logic                         key_enter,
    input  logic                         start_pause,
    input  logic                         clear,
    input  logic                         stage_sel,
    output logic [bcd_width(DIGITS)-1:0] bcd_out,
    output logic                         running,
    output logic                         tim1,
    output logic                         tim2,
    output logic                         stage_done,
    output logic                         alarm
);

    localparam int unsigned W  = bcd_width(DIGITS);
    localparam int unsigned PW = $clog2(TICK_DIV);

    state_t        state, state_n;
    logic [W-1:0]  preset0, preset0_n;
    logic [W-1:0]  preset1, preset1_n;
    logic [W-1:0]  edit_buf, edit_buf_n;
    logic [PW-1:0] prescaler, prescaler_n;
    logic          stage, stage_n;
    logic          stage_done_n;

    logic          cnt_load;
    logic [W-1:0]  cnt_load_val;
    logic          cnt_dec;
    logic [W-1:0]  count;
    logic          cnt_is_zero;
    logic          cnt_is_one;

    logic          digit_key;
    logic          tick;

    assign digit_key = key_valid && (key_code <= KEY_DIGIT_MAX);
    assign tick      = (prescaler == PW'(TICK_DIV - 1));

    bcd_down_counter #(
        .DIGITS  (DIGITS),
        .MIN_SEC (MIN_SEC)
    ) u_counter (
        .clk      (clk),
        .reseta   (reseta),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .value    (count),
        .is_zero  (cnt_is_zero),
        .is_one   (cnt_is_one)
    );

    always_ff @(posedge clk or negedge reseta) begin
        if (!reseta) begin
            state      <= ST_IDLE;
            preset0    <= '0;
            preset1    <= '0;
            edit_buf   <= '0;
            prescaler  <= '0;
            stage      <= 1'b0;
            stage_done <= 1'b0;
        end else begin
            state      <= state_n;
            preset0    <= preset0_n;
            preset1    <= preset1_n;
            edit_buf   <= edit_buf_n;
            prescaler  <= prescaler_n;
            stage      <= stage_n;
            stage_done <= stage_done_n;
        end
    end

    // Event arbitration per state: clear, then start_pause, then key_enter, then digit keys.
    always_comb begin
        state_n      = state;
        preset0_n    = preset0;
        preset1_n    = preset1;
        edit_buf_n   = edit_buf;
        prescaler_n  = prescaler;
        stage_n      = stage;
        stage_done_n = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (clear) begin
                    state_n = ST_IDLE;
                end else if (start_pause) begin
                    if (preset0 != W'(0)) begin
                        cnt_load     = 1'b1;
                        cnt_load_val = preset0;
                        stage_n      = 1'b0;
                        prescaler_n  = '0;
                        state_n      = ST_RUN;
                    end else if (preset1 != W'(0)) begin
                        cnt_load     = 1'b1;
                        cnt_load_val = preset1;
                        stage_n      = 1'b1;
                        prescaler_n  = '0;
                        state_n      = ST_RUN;
                    end
                end else if (!key_enter && digit_key) begin
                    edit_buf_n = {(W-4)'(0), key_code};
                    state_n    = ST_EDIT;
                end
            end
            ST_EDIT: begin
                if (clear) begin
                    edit_buf_n = '0;
                    state_n    = ST_IDLE;
                end else if (key_enter) begin
                    if (stage_sel) preset1_n = edit_buf;
                    else           preset0_n = edit_buf;
                    state_n = ST_IDLE;
                end else if (digit_key) begin
                    edit_buf_n = {edit_buf[W-5:0], key_code};
                end
            end
            ST_RUN: begin
                if (clear) begin
                    cnt_load = 1'b1;
                    state_n  = ST_IDLE;
                end else if (start_pause) begin
                    state_n = ST_PAUSE;
                end else begin
                    prescaler_n = tick ? '0 : prescaler + PW'(1);
                    if (tick) begin
                        if (cnt_is_one || cnt_is_zero) begin
                            cnt_load = 1'b1;
                            if (!stage && preset1 != W'(0)) begin
                                cnt_load_val = preset1;
                                stage_n      = 1'b1;
                                stage_done_n = 1'b1;
                            end else begin
                                state_n = ST_DONE;
                            end
                        end else begin
                            cnt_dec = 1'b1;
                        end
                    end
                end
            end
            ST_PAUSE: begin
                if (clear) begin
                    cnt_load = 1'b1;
                    state_n  = ST_IDLE;
                end else if (start_pause) begin
                    state_n = ST_RUN;
                end
            end
            ST_DONE: begin
                if (clear || start_pause) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        case (state)
            ST_IDLE: bcd_out = stage_sel ? preset1 : preset0;
            ST_EDIT: bcd_out = edit_buf;
            default: bcd_out = count;
        endcase
    end

    assign running = (state == ST_RUN);
    assign tim1    = running && !stage;
    assign tim2    = running && stage;
    assign alarm   = (state == ST_DONE);

endmodule
